aes_key_schedule_seq: RTL and testbench

- Sequential, multi-mode AES key expander. Successor to the single-round combinational expansion used by the cipher core.
- Accepts a 128/192/256-bit cipher key and generates one 32-bit schedule word per clock.
- Packs the words into 128-bit round keys and streams them to the round-key store or cipher datapath over a valid/ready handshake, with backpressure and a done pulse.

---
 rtl/aes_key_schedule_seq.sv | 263 ++++++++++++++++++++++++++
 tb/tb_aes_key_schedule_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule_seq.sv
// ---------------------------------------------------------------------------
// aes_key_schedule_seq
//   Sequential AES key expander for 128/192/256-bit keys. One 32-bit schedule
//   word is produced per clock; every four words are packed into a 128-bit
//   round key and offered on a valid/ready handshake. A one-cycle done pulse
//   follows acceptance of the last round key.
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : request an expansion (taken only when idle and not in the done cycle)
//   key_mode  : 0=AES-128, 1=AES-192, 2=AES-256, 3=treated as AES-128
//   key       : cipher key, left-aligned (w0 = key[255:224])
//   busy      : high from start acceptance until done
//   rk_valid  : rk_data / rk_index hold a round key
//   rk_ready  : consumer accepts the round key
//   rk_data   : {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//   rk_index  : round number r
//   done      : one-cycle pulse after the last round key is accepted
// ---------------------------------------------------------------------------
module aes_key_schedule_seq #(
    parameter int WORD_LENGTH    = 32,
    parameter int MAX_KEY_LENGTH = 256,
    parameter int RK_LENGTH      = 128
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [1:0]                key_mode,
    input  logic [MAX_KEY_LENGTH-1:0] key,
    output logic                      busy,
    output logic                      rk_valid,
    input  logic                      rk_ready,
    output logic [RK_LENGTH-1:0]      rk_data,
    output logic [3:0]                rk_index,
    output logic                      done
);

    typedef logic [WORD_LENGTH-1:0] word_t;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GEN = 2'd1, ST_OUT = 2'd2} state_t;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int n = 0; n < 8; n++) begin
            p  = p ^ (b[n] ? aa : 8'h00);
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // AES S-box: multiplicative inverse (x^254, so 0 maps to 0) then affine map
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] acc;
        p   = x;
        acc = 8'h01;
        for (int n = 0; n < 7; n++) begin
            p   = gf_mul(p, p);
            acc = gf_mul(acc, p);
        end
        return acc ^ {acc[6:0], acc[7]} ^ {acc[5:0], acc[7:6]}
                   ^ {acc[4:0], acc[7:5]} ^ {acc[3:0], acc[7:4]} ^ 8'h63;
    endfunction

    // Four parallel byte lookups
    function automatic word_t sub_word(input word_t x);
        return {sbox_byte(x[31:24]), sbox_byte(x[23:16]),
                sbox_byte(x[15:8]),  sbox_byte(x[7:0])};
    endfunction

    function automatic logic [7:0] xtime8(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    state_t      state_r;
    state_t      state_nx_s;
    logic [1:0]  mode_r;
    logic [1:0]  mode_in_s;
    word_t       win_r [8];       // win_r[0] = newest word, win_r[Nk-1] = w[i-Nk]
    word_t       win_load_s [8];
    word_t       pack_r [3];
    logic [5:0]  i_r;
    logic [2:0]  mod_r;
    logic [7:0]  rcon_r;
    logic [5:0]  nk_s;
    logic [2:0]  nk_m1_s;
    logic [3:0]  nr_s;
    word_t       oldest_s;
    word_t       sub_in_s;
    word_t       sub_out_s;
    word_t       f_s;
    word_t       new_word_s;
    logic        key_phase_s;
    logic        accept_s;
    logic        gen_s;
    logic        take_s;
    logic        last_s;

    // Reserved mode 3 folds onto AES-128
    always_comb begin
        if (key_mode == 2'd3) begin
            mode_in_s = 2'd0;
        end else begin
            mode_in_s = key_mode;
        end
    end

    // Key words loaded so that w0 sits at the oldest slot (Nk-1); positions
    // 0..Nk-1 then rotate as a ring while the key words are replayed
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            win_load_s[k] = 32'h0000_0000;
        end
        case (mode_in_s)
            2'd1:    for (int k = 0; k < 6; k++) win_load_s[k] = key[64 + 32*k +: 32];
            2'd2:    for (int k = 0; k < 8; k++) win_load_s[k] = key[32*k +: 32];
            default: for (int k = 0; k < 4; k++) win_load_s[k] = key[128 + 32*k +: 32];
        endcase
    end

    // Per-mode constants and the oldest window word w[i-Nk]
    always_comb begin
        case (mode_r)
            2'd1: begin nk_s = 6'd6; nk_m1_s = 3'd5; nr_s = 4'd12; oldest_s = win_r[5]; end
            2'd2: begin nk_s = 6'd8; nk_m1_s = 3'd7; nr_s = 4'd14; oldest_s = win_r[7]; end
            default: begin nk_s = 6'd4; nk_m1_s = 3'd3; nr_s = 4'd10; oldest_s = win_r[3]; end
        endcase
    end

    // Schedule word generation for the current index i
    always_comb begin
        key_phase_s = (i_r < nk_s);
        if (mod_r == 3'd0) begin
            sub_in_s = {win_r[0][23:0], win_r[0][31:24]};
        end else begin
            sub_in_s = win_r[0];
        end
        sub_out_s = sub_word(sub_in_s);
        if (mod_r == 3'd0) begin
            f_s = sub_out_s ^ {rcon_r, 24'h00_0000};
        end else if ((mode_r == 2'd2) && (mod_r == 3'd4)) begin
            f_s = sub_out_s;
        end else begin
            f_s = win_r[0];
        end
        if (key_phase_s) begin
            new_word_s = oldest_s;
        end else begin
            new_word_s = oldest_s ^ f_s;
        end
    end

    // Next-state and control strobes for the IDLE/GEN/OUT sequencer
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        gen_s      = 1'b0;
        take_s     = 1'b0;
        last_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // the done cycle still counts as busy for start acceptance
                if (start && !done) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_GEN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_GEN: begin
                gen_s = 1'b1;
                if (i_r[1:0] == 2'd3) begin
                    state_nx_s = ST_OUT;
                end else begin
                    state_nx_s = ST_GEN;
                end
            end
            ST_OUT: begin
                if (rk_ready) begin
                    take_s = 1'b1;
                    if (rk_index == nr_s) begin
                        last_s     = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_GEN;
                    end
                end else begin
                    state_nx_s = ST_OUT;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Key window, counters, packing and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r   <= 2'd0;
            i_r      <= 6'd0;
            mod_r    <= 3'd0;
            rcon_r   <= 8'h01;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_index <= 4'd0;
            done     <= 1'b0;
            for (int k = 0; k < 8; k++) win_r[k] <= 32'h0000_0000;
            for (int k = 0; k < 3; k++) pack_r[k] <= 32'h0000_0000;
        end else begin
            done <= take_s & last_s;
            if (accept_s) begin
                mode_r   <= mode_in_s;
                i_r      <= 6'd0;
                mod_r    <= 3'd0;
                rcon_r   <= 8'h01;
                busy     <= 1'b1;
                rk_valid <= 1'b0;
                rk_index <= 4'd0;
                for (int k = 0; k < 8; k++) win_r[k] <= win_load_s[k];
            end else if (gen_s) begin
                win_r[0] <= new_word_s;
                for (int k = 1; k < 8; k++) win_r[k] <= win_r[k-1];
                i_r   <= i_r + 6'd1;
                mod_r <= (mod_r == nk_m1_s) ? 3'd0 : (mod_r + 3'd1);
                // rcon advances only after it has been consumed
                if (!key_phase_s && (mod_r == 3'd0)) begin
                    rcon_r <= xtime8(rcon_r);
                end
                case (i_r[1:0])
                    2'd0: pack_r[0] <= new_word_s;
                    2'd1: pack_r[1] <= new_word_s;
                    2'd2: pack_r[2] <= new_word_s;
                    2'd3: begin
                        rk_data  <= {pack_r[0], pack_r[1], pack_r[2], new_word_s};
                        rk_valid <= 1'b1;
                    end
                    default: begin end
                endcase
            end else if (take_s) begin
                rk_valid <= 1'b0;
                if (last_s) begin
                    busy <= 1'b0;
                end else begin
                    rk_index <= rk_index + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// ---------------------------------------------------------------------------
// tb_aes_key_schedule_seq
//   Scoreboard bench for aes_key_schedule_seq. Expected round keys come from a
//   behavioural FIPS-197 expansion (table S-box built by inverse search) and
//   are queued at start; a negedge monitor pops and compares on each accepted
//   handshake. Known-answer vectors, latency, backpressure, start filtering
//   and mid-run reset are checked directly.
// ---------------------------------------------------------------------------
module tb_aes_key_schedule_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   key_mode;
    logic [255:0] key;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic         done;

    typedef struct packed {
        logic [127:0] d;
        logic [3:0]   idx;
    } exp_t;

    exp_t         sb_q [$];
    exp_t         mon_e;
    int           n_checks = 0;
    int           n_errors = 0;
    int           n_acc    = 0;
    logic [7:0]   sbox_tab [256];
    logic [7:0]   rcon_tab [10];
    logic [127:0] acc_keys [16];

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    always #5 clk = ~clk;

    aes_key_schedule_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_mode (key_mode),
        .key      (key),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_index (rk_index),
        .done     (done)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int n = 0; n < 8; n++) begin
            if (b[n]) r = r ^ x;
            if (x[7]) x = (x << 1) ^ 8'h1B;
            else      x = x << 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] tb_sub(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int b = 0; b < 8; b++) begin
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
            end
            sbox_tab[x] = s;
        end
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    endtask

    // Reference expansion: queue every round key the DUT must emit
    task automatic push_expected(input logic [1:0] mode, input logic [255:0] k);
        int nk;
        int nr;
        logic [31:0] w [60];
        logic [31:0] t;
        exp_t e;
        case (mode)
            2'd1:    begin nk = 6; nr = 12; end
            2'd2:    begin nk = 8; nr = 14; end
            default: begin nk = 4; nr = 10; end
        endcase
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0)                  t = tb_sub({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
            else if (nk == 8 && i % nk == 4)  t = tb_sub(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            e.d   = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            e.idx = 4'(r);
            sb_q.push_back(e);
        end
    endtask

    // Scoreboard monitor: the handshake completes at the next rising edge
    always @(negedge clk) begin
        if (rst_n && rk_valid && rk_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 128'(sb_q.size()), 128'd1);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("rk_data", rk_data, mon_e.d);
                check_eq("rk_index", 128'(rk_index), 128'(mon_e.idx));
                acc_keys[rk_index] = rk_data;
                n_acc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One expansion; cycles are counted in rising edges after the accept edge
    task automatic run_key(input logic [1:0] mode, input logic [255:0] k, input int stall_idx,
                           input int stall_len, input bit poke, output int done_cyc, output int first_valid);
        int cyc;
        int stalled;
        int waitc;
        logic [127:0] hold_d;
        logic [3:0]   hold_i;
        waitc = 0;
        while ((busy || done) && waitc < 100) begin
            tick();
            waitc++;
        end
        key_mode = mode;
        key      = k;
        start    = 1'b1;
        push_expected(mode, k);
        tick();
        start    = 1'b0;
        key      = ~k;
        key_mode = ~mode;
        check_eq("busy_after_start", 128'(busy), 128'd1);
        cyc = 0; stalled = 0; first_valid = -1; done_cyc = -1;
        hold_d = '0; hold_i = '0;
        while (cyc < 400) begin
            tick();
            cyc++;
            if (first_valid < 0 && rk_valid) first_valid = cyc;
            start = poke && (cyc == 20);
            if (stall_len > 0 && stalled == 0 && rk_valid && 32'(rk_index) == stall_idx) begin
                hold_d   = rk_data;
                hold_i   = rk_index;
                rk_ready = 1'b0;
                stalled  = 1;
            end else if (stalled > 0 && stalled <= stall_len) begin
                check_eq("stall_valid", 128'(rk_valid), 128'd1);
                check_eq("stall_data", rk_data, hold_d);
                check_eq("stall_index", 128'(rk_index), 128'(hold_i));
                if (stalled == stall_len) rk_ready = 1'b1;
                stalled++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int dc;
        int fv;
        int waitc;
        build_tables();
        rst_n = 1'b0; start = 1'b0; key_mode = 2'd0; key = '0; rk_ready = 1'b1;
        repeat (2) tick();
        check_eq("rst_busy", 128'(busy), 128'd0);
        check_eq("rst_valid", 128'(rk_valid), 128'd0);
        check_eq("rst_done", 128'(done), 128'd0);
        check_eq("rst_data", rk_data, 128'd0);
        check_eq("rst_index", 128'(rk_index), 128'd0);
        rst_n = 1'b1;
        tick();

        // AES-128 known answer, ready tied high
        n_acc = 0;
        run_key(2'd0, {K128, 128'h0}, -1, 0, 1'b0, dc, fv);
        check_eq("a128_first_valid", 128'(fv), 128'd4);
        check_eq("a128_done_cyc", 128'(dc), 128'd55);
        check_eq("a128_rk0", acc_keys[0], K128);
        check_eq("a128_rk1", acc_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check_eq("a128_rk10", acc_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check_eq("a128_nkeys", 128'(n_acc), 128'd11);
        check_eq("a128_busy_in_done", 128'(busy), 128'd0);
        tick();
        check_eq("a128_done_width", 128'(done), 128'd0);

        // AES-192
        n_acc = 0;
        run_key(2'd1, {K192, 64'h0}, -1, 0, 1'b0, dc, fv);
        check_eq("a192_done_cyc", 128'(dc), 128'd65);
        check_eq("a192_rk1", acc_keys[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        check_eq("a192_rk12", acc_keys[12], 128'he98ba06f448c773c8ecc720401002202);
        check_eq("a192_nkeys", 128'(n_acc), 128'd13);

        // AES-256
        n_acc = 0;
        run_key(2'd2, K256, -1, 0, 1'b0, dc, fv);
        check_eq("a256_done_cyc", 128'(dc), 128'd75);
        check_eq("a256_rk14", acc_keys[14], 128'hfe4890d1e6188d0b046df344706c631e);
        check_eq("a256_nkeys", 128'(n_acc), 128'd15);
        check_eq("a256_sb_empty", 128'(sb_q.size()), 128'd0);

        // Reserved mode behaves as AES-128
        n_acc = 0;
        run_key(2'd3, {K128, 128'h0}, -1, 0, 1'b0, dc, fv);
        check_eq("m3_done_cyc", 128'(dc), 128'd55);
        check_eq("m3_rk10", acc_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Backpressure: rk3 held 7 cycles
        n_acc = 0;
        run_key(2'd0, {K128, 128'h0}, 3, 7, 1'b0, dc, fv);
        check_eq("bp_done_cyc", 128'(dc), 128'd62);
        check_eq("bp_rk10", acc_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check_eq("bp_nkeys", 128'(n_acc), 128'd11);

        // start while busy and in the done cycle is ignored; next cycle is taken
        n_acc = 0;
        run_key(2'd0, {K128, 128'h0}, -1, 0, 1'b1, dc, fv);
        check_eq("poke_done_cyc", 128'(dc), 128'd55);
        check_eq("poke_nkeys", 128'(n_acc), 128'd11);
        start = 1'b1; key_mode = 2'd2; key = K256;
        tick();
        start = 1'b0;
        check_eq("done_cycle_start_ignored", 128'(busy), 128'd0);
        n_acc = 0;
        run_key(2'd1, {K192, 64'h0}, -1, 0, 1'b0, dc, fv);
        check_eq("restart_done_cyc", 128'(dc), 128'd65);
        check_eq("restart_nkeys", 128'(n_acc), 128'd13);

        // Reset during generation of rk5
        waitc = 0;
        while ((busy || done) && waitc < 100) begin tick(); waitc++; end
        key_mode = 2'd0; key = {K128, 128'h0}; start = 1'b1;
        push_expected(2'd0, {K128, 128'h0});
        tick();
        start = 1'b0;
        waitc = 0;
        while (!(rk_index == 4'd5 && !rk_valid && busy) && waitc < 200) begin tick(); waitc++; end
        check_eq("abort_reached_rk5", 128'(rk_index), 128'd5);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", 128'(busy), 128'd0);
        check_eq("abort_valid", 128'(rk_valid), 128'd0);
        check_eq("abort_data", rk_data, 128'd0);
        check_eq("abort_index", 128'(rk_index), 128'd0);
        sb_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check_eq("abort_no_done", 128'(done), 128'd0);
        check_eq("abort_idle", 128'(busy), 128'd0);
        n_acc = 0;
        run_key(2'd0, {K128, 128'h0}, -1, 0, 1'b0, dc, fv);
        check_eq("post_rst_done_cyc", 128'(dc), 128'd55);
        check_eq("post_rst_rk0", acc_keys[0], K128);
        check_eq("post_rst_rk10", acc_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check_eq("post_rst_nkeys", 128'(n_acc), 128'd11);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
